multicycle_control_fsm: RTL

- Main control state machine for the multicycle CPU; the producer side of the ALU command interface.
- Decodes the latched instruction's opcode/funct, sequences fetch/decode/execute/memory/writeback, and drives the 3-bit ALU command, operand selects and all datapath write enables.
- Consumes the ALU zero flag and a memory ready handshake. One instance sits between the instruction register and the datapath.

---
 rtl/ctrl_pkg.sv | 64 ++++++
 rtl/alu_cmd_decode.sv | 22 ++
 rtl/multicycle_control_fsm.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared control definitions for the multicycle CPU: ALU command codes, opcode/funct
// constants, FSM state encoding and datapath select encodings.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_SLT = 3'd3
    } alu_cmd_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_REGA   = 2'd3;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] B_SEL_REGB     = 2'd0;
    localparam logic [1:0] B_SEL_FOUR     = 2'd1;
    localparam logic [1:0] B_SEL_IMM      = 2'd2;
    localparam logic [1:0] B_SEL_IMM_SHL2 = 2'd3;

endpackage

// File: rtl/alu_cmd_decode.sv
// R-type funct decoder: maps funct to the ALU command and flags unsupported functions.
module alu_cmd_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_cmd,
    output logic       legal
);

    always_comb begin
        alu_cmd = ALU_ADD;
        legal   = 1'b1;
        case (funct)
            FN_ADD:  alu_cmd = ALU_ADD;
            FN_SUB:  alu_cmd = ALU_SUB;
            FN_XOR:  alu_cmd = ALU_XOR;
            FN_SLT:  alu_cmd = ALU_SLT;
            default: legal   = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main multicycle CPU controller: sequences fetch/decode/execute/memory/writeback
// and drives the ALU command, operand selects and datapath write enables.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int JAL_REG         = 31,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_cmd,
    output logic       alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic       imm_zext,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       reg_we,
    output logic       iord,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst_sel,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    // reg_dst_sel=2 makes the datapath write register JAL_REG; it must address the file.
    generate
        if (JAL_REG < 0 || JAL_REG > 31) begin : g_jal_reg_range
            $error("JAL_REG out of range 0..31");
        end
    endgenerate

    state_t     state_reg;
    state_t     state_next;
    state_t     illegal_target;
    logic       illegal_reg;
    logic [2:0] r_cmd;
    logic       r_legal;
    logic       pc_we_raw;
    logic       ir_we_raw;
    logic       mem_re_raw;
    logic       mem_we_raw;
    logic       reg_we_raw;

    alu_cmd_decode u_alu_cmd_decode (
        .funct   (funct),
        .alu_cmd (r_cmd),
        .legal   (r_legal)
    );

    assign illegal_target = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= (state_next == S_TRAP);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:    state_next = S_MEM_ADDR;
                    OP_RTYPE:        state_next = (funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_ADDI, OP_XORI: state_next = S_EXEC_I;
                    OP_BEQ, OP_BNE:  state_next = S_BRANCH;
                    OP_J:            state_next = S_JUMP;
                    OP_JAL:          state_next = S_JAL;
                    default:         state_next = illegal_target;
                endcase
            end
            S_MEM_ADDR: state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
            S_EXEC_R:   state_next = r_legal ? S_WB_R : illegal_target;
            S_EXEC_I:   state_next = S_WB_I;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        alu_cmd     = ALU_ADD;
        alu_a_sel   = 1'b0;
        alu_b_sel   = B_SEL_REGB;
        imm_zext    = 1'b0;
        iord        = 1'b0;
        pc_src      = PC_SRC_ALU;
        reg_dst_sel = REG_DST_RT;
        wb_sel      = WB_ALUOUT;
        pc_we_raw   = 1'b0;
        ir_we_raw   = 1'b0;
        mem_re_raw  = 1'b0;
        mem_we_raw  = 1'b0;
        reg_we_raw  = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_re_raw = 1'b1;
                alu_b_sel  = B_SEL_FOUR;
                ir_we_raw  = mem_ready;
                pc_we_raw  = mem_ready;
            end
            // Branch target is computed speculatively here and held in ALUOut.
            S_DECODE:   alu_b_sel = B_SEL_IMM_SHL2;
            S_MEM_ADDR: begin
                alu_a_sel = 1'b1;
                alu_b_sel = B_SEL_IMM;
            end
            S_MEM_RD: begin
                iord       = 1'b1;
                mem_re_raw = 1'b1;
            end
            S_MEM_WB: begin
                reg_we_raw = 1'b1;
                wb_sel     = WB_MDR;
            end
            S_MEM_WR: begin
                iord       = 1'b1;
                mem_we_raw = 1'b1;
            end
            S_EXEC_R: begin
                alu_a_sel = 1'b1;
                alu_cmd   = r_cmd;
            end
            S_WB_R: begin
                reg_we_raw  = 1'b1;
                reg_dst_sel = REG_DST_RD;
            end
            S_EXEC_I: begin
                alu_a_sel = 1'b1;
                alu_b_sel = B_SEL_IMM;
                if (opcode == OP_XORI) begin
                    alu_cmd  = ALU_XOR;
                    imm_zext = 1'b1;
                end
            end
            S_WB_I: reg_we_raw = 1'b1;
            S_BRANCH: begin
                alu_a_sel = 1'b1;
                alu_cmd   = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_we_raw = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_we_raw = 1'b1;
                pc_src    = PC_SRC_JUMP;
            end
            S_JAL: begin
                pc_we_raw   = 1'b1;
                pc_src      = PC_SRC_JUMP;
                reg_we_raw  = 1'b1;
                reg_dst_sel = REG_DST_RA;
                wb_sel      = WB_PC;
            end
            S_JR: begin
                pc_we_raw = 1'b1;
                pc_src    = PC_SRC_REGA;
            end
            default: ;
        endcase
    end

    // Enables are gated by reset so an access in flight is dropped immediately.
    assign pc_we     = pc_we_raw  & reset_n;
    assign ir_we     = ir_we_raw  & reset_n;
    assign mem_re    = mem_re_raw & reset_n;
    assign mem_we    = mem_we_raw & reset_n;
    assign reg_we    = reg_we_raw & reset_n;
    assign illegal   = illegal_reg;
    assign state_dbg = state_reg;

endmodule
